// File: rtl/div_pkg.sv
// Shared constants, op encodings and state type for the RV32M divide sequencer.
package div_pkg;

  localparam int DIV_XLEN = 32;

  localparam logic [2:0] OP_DIV  = 3'b100;
  localparam logic [2:0] OP_DIVU = 3'b101;
  localparam logic [2:0] OP_REM  = 3'b110;
  localparam logic [2:0] OP_REMU = 3'b111;

  localparam logic [DIV_XLEN-1:0] SDIV_MIN  = 32'h8000_0000;
  localparam logic [DIV_XLEN-1:0] SDIV_NEG1 = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_t;

  // 0x80000000 maps to itself, which is the correct unsigned magnitude.
  function automatic logic [DIV_XLEN-1:0] magnitude(input logic [DIV_XLEN-1:0] value,
                                                     input logic is_signed);
    return (is_signed && value[DIV_XLEN-1]) ? -value : value;
  endfunction

endpackage

// File: rtl/div_datapath.sv
// Restoring-divide datapath: remainder/quotient/divisor registers and the
// ITER_PER_CYCLE trial-subtract chain, driven by load/step/fix strobes.
module div_datapath #(
  parameter int XLEN           = 32,
  parameter int ITER_PER_CYCLE = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            step,
  input  logic            fix,
  input  logic [XLEN-1:0] a_mag,
  input  logic [XLEN-1:0] b_mag,
  input  logic            neg_quo,
  input  logic            neg_rem,
  output logic [XLEN-1:0] quo_out,
  output logic [XLEN-1:0] rem_out
);

  logic [XLEN-1:0] quo_q;
  logic [XLEN-1:0] rem_q;
  logic [XLEN-1:0] div_q;
  logic            neg_quo_q;
  logic            neg_rem_q;

  logic [XLEN-1:0] quo_nxt;
  logic [XLEN-1:0] rem_nxt;
  logic [XLEN-1:0] r_v;
  logic [XLEN-1:0] q_v;
  logic [XLEN:0]   shifted_v;
  logic [XLEN:0]   diff_v;

  // Trial subtract at XLEN+1 bits so the borrow lands in the top bit.
  always_comb begin
    r_v       = rem_q;
    q_v       = quo_q;
    shifted_v = '0;
    diff_v    = '0;
    for (int i = 0; i < ITER_PER_CYCLE; i++) begin
      shifted_v = {r_v, q_v[XLEN-1]};
      q_v       = {q_v[XLEN-2:0], 1'b0};
      diff_v    = shifted_v - {1'b0, div_q};
      if (!diff_v[XLEN]) begin
        r_v    = diff_v[XLEN-1:0];
        q_v[0] = 1'b1;
      end else begin
        r_v = shifted_v[XLEN-1:0];
      end
    end
    quo_nxt = q_v;
    rem_nxt = r_v;
  end

  assign quo_out = neg_quo_q ? -quo_q : quo_q;
  assign rem_out = neg_rem_q ? -rem_q : rem_q;

  // fix folds the sign correction into the registers so the outputs stay valid afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quo_q     <= '0;
      rem_q     <= '0;
      div_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else if (load) begin
      quo_q     <= a_mag;
      rem_q     <= '0;
      div_q     <= b_mag;
      neg_quo_q <= neg_quo;
      neg_rem_q <= neg_rem;
    end else if (step) begin
      quo_q <= quo_nxt;
      rem_q <= rem_nxt;
    end else if (fix) begin
      quo_q     <= quo_out;
      rem_q     <= rem_out;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end
  end

endmodule

// File: rtl/div_seq_ctrl.sv
// Sequencing controller for RV32M DIV/DIVU/REM/REMU with valid/ready request and response.
// Optional DIV_REM_FUSE_EN reuses the last computed quotient/remainder pair.
module div_seq_ctrl
  import div_pkg::*;
#(
  parameter int XLEN           = DIV_XLEN,
  parameter int ITER_PER_CYCLE = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            kill,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] result,
  output logic            zero_division,
  output logic            overflow_signed_div,
  output logic            busy
);

  localparam int              CNT_W    = $clog2(XLEN);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(XLEN / ITER_PER_CYCLE - 1);

  state_t          state;
  logic [CNT_W-1:0] cnt;
  logic            is_rem_q;

  logic            req_signed;
  logic            req_rem;
  logic            accept;
  logic            fuse_hit;
  logic            dp_load;
  logic            dp_step;
  logic            dp_fix;
  logic [XLEN-1:0] quo_out;
  logic [XLEN-1:0] rem_out;

  assign req_ready  = (state == IDLE);
  assign busy       = (state != IDLE);
  assign req_signed = (op == OP_DIV) || (op == OP_REM);
  assign req_rem    = (op == OP_REM) || (op == OP_REMU);
  assign accept     = req_valid && req_ready && !kill;

  assign dp_load = accept && !fuse_hit;
  assign dp_step = (state == CALC) && !kill;
  assign dp_fix  = (state == FIX) && !kill;

  div_datapath #(
    .XLEN          (XLEN),
    .ITER_PER_CYCLE(ITER_PER_CYCLE)
  ) u_datapath (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (dp_load),
    .step   (dp_step),
    .fix    (dp_fix),
    .a_mag  (magnitude(a, req_signed)),
    .b_mag  (magnitude(b, req_signed)),
    .neg_quo(req_signed && (a[XLEN-1] ^ b[XLEN-1])),
    .neg_rem(req_signed && a[XLEN-1]),
    .quo_out(quo_out),
    .rem_out(rem_out)
  );

`ifdef DIV_REM_FUSE_EN
  logic            fuse_valid;
  logic            fuse_signed;
  logic            fuse_rem;
  logic [XLEN-1:0] fuse_a;
  logic [XLEN-1:0] fuse_b;

  assign fuse_hit = fuse_valid && (a == fuse_a) && (b == fuse_b) &&
                    (req_signed == fuse_signed) && (req_rem != fuse_rem);

  // Operands are captured on every datapath load; the entry becomes usable once FIX completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fuse_valid  <= 1'b0;
      fuse_signed <= 1'b0;
      fuse_rem    <= 1'b0;
      fuse_a      <= '0;
      fuse_b      <= '0;
    end else if (kill) begin
      fuse_valid <= 1'b0;
    end else if (dp_load) begin
      fuse_valid  <= 1'b0;
      fuse_signed <= req_signed;
      fuse_rem    <= req_rem;
      fuse_a      <= a;
      fuse_b      <= b;
    end else if (dp_fix) begin
      fuse_valid <= 1'b1;
    end
  end
`else
  assign fuse_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state               <= IDLE;
      cnt                 <= '0;
      is_rem_q            <= 1'b0;
      result              <= '0;
      zero_division       <= 1'b0;
      overflow_signed_div <= 1'b0;
      resp_valid          <= 1'b0;
    end else if (kill) begin
      state      <= IDLE;
      resp_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            is_rem_q            <= req_rem;
            cnt                 <= CNT_LOAD;
            zero_division       <= 1'b0;
            overflow_signed_div <= 1'b0;
            if (b == '0) begin
              state         <= DONE;
              resp_valid    <= 1'b1;
              zero_division <= 1'b1;
              result        <= req_rem ? a : SDIV_NEG1;
            end else if (req_signed && (a == SDIV_MIN) && (b == SDIV_NEG1)) begin
              state               <= DONE;
              resp_valid          <= 1'b1;
              overflow_signed_div <= 1'b1;
              result              <= req_rem ? '0 : SDIV_MIN;
            end else if (fuse_hit) begin
              state      <= DONE;
              resp_valid <= 1'b1;
              result     <= req_rem ? rem_out : quo_out;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == '0) begin
            state <= FIX;
          end
        end
        FIX: begin
          result              <= is_rem_q ? rem_out : quo_out;
          zero_division       <= 1'b0;
          overflow_signed_div <= 1'b0;
          resp_valid          <= 1'b1;
          state               <= DONE;
        end
        DONE: begin
          if (resp_ready) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Directed self-checking bench for div_seq_ctrl; fused-latency expectations follow DIV_REM_FUSE_EN.
module tb_div_seq_ctrl;
  import div_pkg::*;

`ifdef DIV_REM_FUSE_EN
  localparam int FUSED_EDGES = 0;
`else
  localparam int FUSED_EDGES = 33;
`endif

  logic        clk        = 1'b0;
  logic        rst_n      = 1'b1;
  logic        req_valid  = 1'b0;
  logic        kill       = 1'b0;
  logic        resp_ready = 1'b0;
  logic [2:0]  op         = OP_DIV;
  logic [31:0] a          = '0;
  logic [31:0] b          = '0;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] result;
  logic        zero_division;
  logic        overflow_signed_div;
  logic        busy;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  div_seq_ctrl dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .req_valid          (req_valid),
    .req_ready          (req_ready),
    .op                 (op),
    .a                  (a),
    .b                  (b),
    .kill               (kill),
    .resp_valid         (resp_valid),
    .resp_ready         (resp_ready),
    .result             (result),
    .zero_division      (zero_division),
    .overflow_signed_div(overflow_signed_div),
    .busy               (busy)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Presents one request for exactly one rising edge; caller starts #1 after an edge.
  task automatic applyStimulus(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    checkOutput("req_ready_idle", 32'(req_ready), 32'd1);
    op        = o;
    a         = x;
    b         = y;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  // Counts edges after the accept edge until resp_valid; bounded so a hang shows as a bad latency.
  task automatic waitResponse(output int edges);
    edges = 0;
    while (resp_valid !== 1'b1 && edges < 200) begin
      @(posedge clk);
      #1;
      edges++;
    end
  endtask

  task automatic finishResponse();
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    checkOutput("busy_after_handshake", 32'(busy), 32'd0);
  endtask

  task automatic runOp(input string tag, input logic [2:0] o, input logic [31:0] x,
                       input logic [31:0] y, input logic [31:0] exp_res,
                       input logic zd, input logic ov, input int exp_edges);
    int edges;
    applyStimulus(o, x, y);
    waitResponse(edges);
    checkOutput($sformatf("%s_latency", tag), 32'(edges), 32'(exp_edges));
    checkOutput($sformatf("%s_result", tag), result, exp_res);
    checkOutput($sformatf("%s_flags", tag), 32'({zero_division, overflow_signed_div}),
                32'({zd, ov}));
    finishResponse();
  endtask

  initial begin
    int edges;
    int seen;

    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_resp_valid", 32'(resp_valid), 32'd0);
    checkOutput("reset_result", result, 32'd0);
    checkOutput("reset_flags", 32'({zero_division, overflow_signed_div}), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_req_ready", 32'(req_ready), 32'd1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    runOp("div_neg20_3", OP_DIV, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFA, 1'b0, 1'b0, 33);
    runOp("rem_neg20_3", OP_REM, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFE, 1'b0, 1'b0, FUSED_EDGES);
    runOp("divu_by_zero", OP_DIVU, 32'h1234, 32'd0, 32'hFFFF_FFFF, 1'b1, 1'b0, 0);
    runOp("remu_by_zero", OP_REMU, 32'h1234, 32'd0, 32'h0000_1234, 1'b1, 1'b0, 0);
    runOp("div_overflow", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1'b1, 0);
    runOp("rem_overflow", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b1, 0);
    runOp("divu_ovf_ops", OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0, 33);
    runOp("remu_ovf_ops", OP_REMU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1'b0,
          FUSED_EDGES);
    runOp("div_7_neg2", OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0, 1'b0, 33);
    runOp("rem_neg7_2", OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0, 1'b0, 33);
    runOp("divu_big", OP_DIVU, 32'hFFFF_FFFF, 32'h8000_0001, 32'd1, 1'b0, 1'b0, 33);
    runOp("div_min_2", OP_DIV, 32'h8000_0000, 32'd2, 32'hC000_0000, 1'b0, 1'b0, 33);

    applyStimulus(OP_DIVU, 32'd100, 32'd7);
    waitResponse(edges);
    checkOutput("bp_latency", 32'(edges), 32'd33);
    op        = OP_REMU;
    a         = 32'd55;
    b         = 32'd4;
    req_valid = 1'b1;
    repeat (5) begin
      @(posedge clk);
      #1;
      checkOutput("bp_resp_valid", 32'(resp_valid), 32'd1);
      checkOutput("bp_result", result, 32'd14);
      checkOutput("bp_flags", 32'({zero_division, overflow_signed_div}), 32'd0);
      checkOutput("bp_req_ready", 32'(req_ready), 32'd0);
    end
    req_valid = 1'b0;
    finishResponse();
    checkOutput("bp_req_ready_after", 32'(req_ready), 32'd1);

    applyStimulus(OP_DIV, 32'd1000, 32'd3);
    repeat (10) begin
      @(posedge clk);
      #1;
    end
    checkOutput("kill_busy_before", 32'(busy), 32'd1);
    kill = 1'b1;
    @(posedge clk);
    #1;
    kill = 1'b0;
    checkOutput("kill_busy", 32'(busy), 32'd0);
    checkOutput("kill_resp_valid", 32'(resp_valid), 32'd0);
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (resp_valid) seen++;
    end
    checkOutput("kill_no_response", 32'(seen), 32'd0);
    runOp("divu_after_kill", OP_DIVU, 32'd100, 32'd7, 32'd14, 1'b0, 1'b0, 33);

    op        = OP_DIVU;
    a         = 32'd9;
    b         = 32'd3;
    req_valid = 1'b1;
    kill      = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    kill      = 1'b0;
    checkOutput("kill_beats_accept", 32'(busy), 32'd0);

    runOp("fuse_div", OP_DIV, 32'd100, 32'd7, 32'd14, 1'b0, 1'b0, 33);
    runOp("fuse_rem", OP_REM, 32'd100, 32'd7, 32'd2, 1'b0, 1'b0, FUSED_EDGES);
    runOp("refill_div", OP_DIV, 32'd100, 32'd7, 32'd14, 1'b0, 1'b0, 33);
    kill = 1'b1;
    @(posedge clk);
    #1;
    kill = 1'b0;
    runOp("rem_after_kill", OP_REM, 32'd100, 32'd7, 32'd2, 1'b0, 1'b0, 33);

    applyStimulus(OP_DIV, 32'd500, 32'd9);
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midop_reset_busy", 32'(busy), 32'd0);
    checkOutput("midop_reset_resp_valid", 32'(resp_valid), 32'd0);
    checkOutput("midop_reset_result", result, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    runOp("remu_after_reset", OP_REMU, 32'd100, 32'd7, 32'd2, 1'b0, 1'b0, 33);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
